// File: rtl/m14k_wsram_pkg.sv
// m14k_wsram_pkg: shared types and constants for the way-select SRAM controller.
//   - FSM state encoding (INIT sweep / RUN)
//   - write-buffer entry layout {idx, mask, data}
//   - field positions of the LRU and dirty bits inside a WS entry
//   - ws_merge: per-bit masked overlay used by both the SRAM write and read bypass
package m14k_wsram_pkg;

  localparam int WS_WIDTH_P = 10;
  localparam int WS_DEPTH_P = 8;
  localparam int WB_DEPTH_P = 2;

  localparam int WS_LRU_LSB   = 0;
  localparam int WS_LRU_MSB   = 5;
  localparam int WS_DIRTY_LSB = 6;
  localparam int WS_DIRTY_MSB = 9;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ws_state_e;

  typedef struct packed {
    logic [WS_DEPTH_P-1:0] idx;
    logic [WS_WIDTH_P-1:0] mask;
    logic [WS_WIDTH_P-1:0] data;
  } wb_entry_t;

  // Bits set in mask take their value from data, the rest keep base.
  function automatic logic [WS_WIDTH_P-1:0] ws_merge(
    input logic [WS_WIDTH_P-1:0] base,
    input logic [WS_WIDTH_P-1:0] mask,
    input logic [WS_WIDTH_P-1:0] data
  );
    return (base & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/m14k_wsram_wbuf.sv
// m14k_wsram_wbuf: 2-entry update FIFO in front of the WS SRAM.
//   Slot 0 always holds the oldest entry, so the parent drains ent0 and
//   applies ent0 then ent1 when bypassing reads.
// Ports:
//   clk, greset_n      clock, async active-low reset
//   clr                drop all entries (takes priority over push/pop)
//   push, push_ent     append an entry at the tail
//   pop                remove the head entry
//   full, empty        occupancy flags
//   ent0/ent0_vld      head entry and its valid bit
//   ent1/ent1_vld      second entry and its valid bit
module m14k_wsram_wbuf
  import m14k_wsram_pkg::*;
(
  input  logic      clk,
  input  logic      greset_n,
  input  logic      clr,
  input  logic      push,
  input  wb_entry_t push_ent,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t ent0,
  output logic      ent0_vld,
  output wb_entry_t ent1,
  output logic      ent1_vld
);

  wb_entry_t slot0_r;
  wb_entry_t slot1_r;
  logic      vld0_r;
  logic      vld1_r;

  // Shift FIFO: pops move slot1 down; pushes fill the first free slot.
  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      slot0_r <= '{idx: {WS_DEPTH_P{1'b0}}, mask: {WS_WIDTH_P{1'b0}}, data: {WS_WIDTH_P{1'b0}}};
      slot1_r <= '{idx: {WS_DEPTH_P{1'b0}}, mask: {WS_WIDTH_P{1'b0}}, data: {WS_WIDTH_P{1'b0}}};
      vld0_r  <= 1'b0;
      vld1_r  <= 1'b0;
    end else if (clr) begin
      vld0_r <= 1'b0;
      vld1_r <= 1'b0;
    end else begin
      case ({push, pop})
        2'b11: begin
          // Occupancy unchanged: head leaves, new entry joins the tail.
          if (vld1_r) begin
            slot0_r <= slot1_r;
            slot1_r <= push_ent;
          end else begin
            slot0_r <= push_ent;
          end
        end
        2'b01: begin
          slot0_r <= slot1_r;
          vld0_r  <= vld1_r;
          vld1_r  <= 1'b0;
        end
        2'b10: begin
          if (!vld0_r) begin
            slot0_r <= push_ent;
            vld0_r  <= 1'b1;
          end else begin
            slot1_r <= push_ent;
            vld1_r  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign full     = vld1_r;
  assign empty    = ~vld0_r;
  assign ent0     = slot0_r;
  assign ent0_vld = vld0_r;
  assign ent1     = slot1_r;
  assign ent1_vld = vld1_r;

endmodule

// File: rtl/m14k_wsram_ctl.sv
// m14k_wsram_ctl: sequences the single-port way-select (LRU/dirty) SRAM.
//   After reset or init_req it sweeps every entry to zero (busy=1), then
//   shares the SRAM port between lookup reads and buffered update writes.
//   Reads see pending buffered updates through a bypass merge.
// Ports:
//   clk, greset_n            clock, async active-low reset
//   init_req / busy          re-run the clearing sweep / sweep in progress
//   rd_req/rd_idx/rd_ready   lookup read handshake
//   rd_valid/rd_data         read return, one cycle after accept
//   upd_valid/upd_ready      update handshake with upd_idx/upd_mask/upd_data
//   ws_*                     SRAM wrapper interface (ws_rd_data lags ws_rd_str by 1)
module m14k_wsram_ctl
  import m14k_wsram_pkg::*;
#(
  parameter int WS_WIDTH = WS_WIDTH_P,
  parameter int WS_DEPTH = WS_DEPTH_P
) (
  input  logic                clk,
  input  logic                greset_n,
  input  logic                init_req,
  output logic                busy,
  input  logic                rd_req,
  input  logic [WS_DEPTH-1:0] rd_idx,
  output logic                rd_ready,
  output logic                rd_valid,
  output logic [WS_WIDTH-1:0] rd_data,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [WS_DEPTH-1:0] upd_idx,
  input  logic [WS_WIDTH-1:0] upd_mask,
  input  logic [WS_WIDTH-1:0] upd_data,
  output logic [WS_DEPTH-1:0] ws_line_idx,
  output logic                ws_rd_str,
  output logic                ws_wr_str,
  output logic [WS_WIDTH-1:0] ws_wr_mask,
  output logic [WS_WIDTH-1:0] ws_wr_data,
  input  logic [WS_WIDTH-1:0] ws_rd_data
);

  ws_state_e           state_r;
  ws_state_e           state_nx_s;
  logic [WS_DEPTH-1:0] cnt_r;
  logic [WS_DEPTH-1:0] cnt_nx_s;

  logic      full_s, empty_s, e0_vld_s, e1_vld_s;
  wb_entry_t e0_s, e1_s, push_ent_s;
  logic      drain_s, rd_issue_s, push_s, clr_s;

  logic                rd_pend_r;
  logic                hit0_r, hit1_r;
  logic [WS_WIDTH-1:0] snap0_mask_r, snap0_data_r, snap1_mask_r, snap1_data_r;
  logic [WS_WIDTH-1:0] rd_hold_r;
  logic [WS_WIDTH-1:0] merge0_s, merged_s;

  assign push_ent_s = '{idx: upd_idx, mask: upd_mask, data: upd_data};
  assign push_s     = upd_valid & upd_ready;
  assign clr_s      = (state_r == ST_RUN) & init_req;

  m14k_wsram_wbuf u_wbuf (
    .clk      (clk),
    .greset_n (greset_n),
    .clr      (clr_s),
    .push     (push_s),
    .push_ent (push_ent_s),
    .pop      (drain_s),
    .full     (full_s),
    .empty    (empty_s),
    .ent0     (e0_s),
    .ent0_vld (e0_vld_s),
    .ent1     (e1_s),
    .ent1_vld (e1_vld_s)
  );

  // Port arbitration: a full buffer always drains first so updates cannot starve.
  always_comb begin
    rd_ready    = 1'b0;
    upd_ready   = 1'b0;
    rd_issue_s  = 1'b0;
    drain_s     = 1'b0;
    ws_rd_str   = 1'b0;
    ws_wr_str   = 1'b0;
    ws_line_idx = {WS_DEPTH{1'b0}};
    ws_wr_mask  = {WS_WIDTH{1'b0}};
    ws_wr_data  = {WS_WIDTH{1'b0}};
    if (!greset_n) begin
      // Hold the SRAM interface quiet while reset is asserted.
      ws_wr_str = 1'b0;
    end else if (state_r == ST_INIT) begin
      ws_wr_str   = 1'b1;
      ws_line_idx = cnt_r;
      ws_wr_mask  = {WS_WIDTH{1'b1}};
      ws_wr_data  = {WS_WIDTH{1'b0}};
    end else begin
      rd_ready   = ~full_s;
      rd_issue_s = rd_req & ~full_s;
      // Entries about to be discarded by init_req are never written.
      drain_s    = ~init_req & (full_s | (~rd_req & ~empty_s));
      upd_ready  = ~full_s | drain_s;
      if (rd_issue_s) begin
        ws_rd_str   = 1'b1;
        ws_line_idx = rd_idx;
      end else if (drain_s) begin
        ws_wr_str   = 1'b1;
        ws_line_idx = e0_s.idx;
        ws_wr_mask  = e0_s.mask;
        ws_wr_data  = e0_s.data;
      end else begin
        ws_line_idx = {WS_DEPTH{1'b0}};
      end
    end
  end

  // Next state and sweep counter; the counter wraps to 0 as the sweep ends.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_nx_s = cnt_r + 1'b1;
        if (cnt_r == {WS_DEPTH{1'b1}}) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_INIT;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_nx_s = ST_INIT;
          cnt_nx_s   = {WS_DEPTH{1'b0}};
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s = ST_INIT;
        cnt_nx_s   = {WS_DEPTH{1'b0}};
      end
    endcase
  end

  // State, counter and the read-return pipeline with its bypass snapshot.
  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      state_r      <= ST_INIT;
      cnt_r        <= {WS_DEPTH{1'b0}};
      rd_pend_r    <= 1'b0;
      hit0_r       <= 1'b0;
      hit1_r       <= 1'b0;
      snap0_mask_r <= {WS_WIDTH{1'b0}};
      snap0_data_r <= {WS_WIDTH{1'b0}};
      snap1_mask_r <= {WS_WIDTH{1'b0}};
      snap1_data_r <= {WS_WIDTH{1'b0}};
      rd_hold_r    <= {WS_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      rd_pend_r    <= rd_issue_s;
      hit0_r       <= rd_issue_s & e0_vld_s & (e0_s.idx == rd_idx);
      hit1_r       <= rd_issue_s & e1_vld_s & (e1_s.idx == rd_idx);
      snap0_mask_r <= e0_s.mask;
      snap0_data_r <= e0_s.data;
      snap1_mask_r <= e1_s.mask;
      snap1_data_r <= e1_s.data;
      if (rd_pend_r) begin
        rd_hold_r <= merged_s;
      end
    end
  end

  // Overlay the snapshotted entries on the SRAM word, oldest first.
  assign merge0_s = hit0_r ? ws_merge(ws_rd_data, snap0_mask_r, snap0_data_r) : ws_rd_data;
  assign merged_s = hit1_r ? ws_merge(merge0_s, snap1_mask_r, snap1_data_r) : merge0_s;

  assign busy     = (state_r == ST_INIT);
  assign rd_valid = rd_pend_r;
  assign rd_data  = rd_pend_r ? merged_s : rd_hold_r;

endmodule

// File: doc/m14k_wsram_ctl.md
Name: m14k_wsram_ctl

Overview:
Controller that sequences the single-port way-select SRAM (LRU/dirty bits) of an L1 cache.
It accepts tag-pipeline lookup reads and LRU/dirty update writes, and shares the one SRAM port between them. Updates are held in a 2-entry write buffer with read bypass. After reset, or on request, it runs an init sweep that clears every entry.
It sits between the cache control pipeline and the WS SRAM wrapper.

Parameters:
WS_WIDTH, 10, bits per WS entry (LRU [5:0], dirty [9:6])
WS_DEPTH, 8, index bits; the array holds 2^WS_DEPTH entries
WB_DEPTH, 2, write-buffer entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  clock
greset_n  in  1  asynchronous active-low reset
init_req  in  1  pulse: discard buffer, re-run init sweep
busy  out  1  init sweep in progress
rd_req  in  1  lookup read request
rd_idx  in  WS_DEPTH  lookup index
rd_ready  out  1  read accepted when rd_req&rd_ready
rd_valid  out  1  read data valid (1 cycle after accept)
rd_data  out  WS_WIDTH  merged read data
upd_valid  in  1  update request
upd_ready  out  1  update accepted when upd_valid&upd_ready
upd_idx  in  WS_DEPTH  update index
upd_mask  in  WS_WIDTH  per-bit write mask
upd_data  in  WS_WIDTH  update data
ws_line_idx  out  WS_DEPTH  SRAM index
ws_rd_str  out  1  SRAM read strobe
ws_wr_str  out  1  SRAM write strobe
ws_wr_mask  out  WS_WIDTH  SRAM bit write mask
ws_wr_data  out  WS_WIDTH  SRAM write data
ws_rd_data  in  WS_WIDTH  SRAM read data, valid the cycle after ws_rd_str

Behaviour:
- Reset (greset_n low, async):
  - state=INIT, sweep counter=0, buffer empty.
  - busy=1, rd_ready=0, upd_ready=0, rd_valid=0, rd_data=0.
  - ws_rd_str=0, ws_wr_str=0, ws_line_idx=0, ws_wr_mask=0, ws_wr_data=0.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle: ws_wr_str=1, ws_line_idx=counter, ws_wr_mask=all ones, ws_wr_data=0; counter increments.
  - After writing index 2^WS_DEPTH-1, the next cycle is RUN with busy=0. The sweep takes exactly 2^WS_DEPTH cycles.
  - init_req is ignored during INIT.
  - rd_ready=0 and upd_ready=0 throughout.
- RUN, port arbitration (one SRAM op per cycle; all port outputs registered-free, i.e. combinational from state):
  - Buffer full (2 entries): drain the oldest entry; rd_ready=0. This prevents write starvation.
  - Otherwise, if rd_req: issue the read (ws_rd_str=1, ws_line_idx=rd_idx); rd_ready=1; no drain.
  - Otherwise, if the buffer is non-empty: drain the oldest entry (ws_wr_str=1, ws_line_idx/ws_wr_mask/ws_wr_data from that entry).
- RUN, update acceptance:
  - upd_ready = buffer not full, or an entry drains this cycle.
  - An accepted update is appended at the tail. No coalescing.
  - An update accepted in the same cycle as a read is ordered after that read; the read does not see it.
- Read bypass:
  - At read issue (cycle T), snapshot every buffer entry whose index equals rd_idx (oldest first).
  - At T+1: rd_valid=1 and rd_data = ws_rd_data with the snapshot entries applied in order, per bit: d = (d & ~mask) | (data & mask).
  - Read latency is exactly 1 cycle. rd_valid=0 otherwise. rd_data holds its last value when rd_valid=0.
- init_req in RUN:
  - Next cycle: buffer cleared (pending updates discarded), state=INIT, counter=0, busy=1.
  - A read issued in the init_req cycle still returns rd_valid at T+1.
- Reset mid-sweep or mid-drain restarts from the reset state.
- Simultaneous drain and accept with the buffer full: the head pops and the new entry is pushed in the same cycle; occupancy is unchanged.

Decomposition:
- Package m14k_wsram_pkg holds:
  - FSM state encoding (INIT, RUN).
  - The write-buffer entry struct {idx, mask, data}.
  - Constants WS_LRU_LSB=0, WS_LRU_MSB=5, WS_DIRTY_LSB=6, WS_DIRTY_MSB=9.
- Sub-module m14k_wsram_wbuf: 2-entry FIFO with push/pop/full/empty. It exposes both entries with valid bits so the parent can run the bypass compare.

Test Plan:
- Reset release: busy=1 for 256 cycles (WS_DEPTH=8) with ws_wr_str=1, ws_line_idx 0..255, ws_wr_data=0. Then busy=0 and a read of idx 0x37 returns rd_data=0 one cycle after accept.
- Update idx 0x12 mask 0x3C0 data 0x3FF, with no reads pending: drained the next cycle with ws_wr_mask=0x3C0. A later read of 0x12 returns 0x3C0.
- Continuous rd_req every cycle plus two updates to 0x05 (mask 0x004 data 0x004, then mask 0x0C0 data 0x040): the buffer fills and rd_ready drops for 1 cycle while the oldest drains. Meanwhile a read of 0x05 during buffering returns 0x044 (SRAM 0x000 merged with both entries).
- Update and read to idx 0x20 accepted in the same cycle: the read returns the pre-update value 0x000. The next read of 0x20 returns the updated value.
- With 2 buffered updates, pulse init_req: the updates are never written (no ws_wr_str with mask≠all-ones). A 256-cycle sweep follows, and every subsequent read returns 0.
- Assert greset_n=0 at sweep index 100: outputs return to reset values immediately, and the sweep restarts from index 0 on release.
